// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// The state encoding is fixed because state_o drives LEDs directly.
package alu_seq_pkg;

  localparam int DEBOUNCE_DEFAULT = 500000;

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'b00,
    S_LOAD_B  = 2'b01,
    S_LOAD_OP = 2'b10,
    S_READY   = 2'b11
  } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw push-button, filters bounce and emits one pulse per accepted press.
module button_debouncer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_pulse;
  logic [CW-1:0] r_count;

  // A new level is accepted only after it has differed from the accepted level for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta     <= 1'b0;
      r_sync     <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_meta     <= btn_raw;
      r_sync     <= r_meta;
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
      if (r_sync == r_stable) begin
        r_count <= '0;
      end else if (r_count == CNT_LAST) begin
        r_stable <= r_sync;
        r_count  <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign press_pulse = r_pulse;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Builds a registered ALU operand set (a, b, op, add/sub selects) in three button-driven load steps.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic [2:0]   op_sw,
  input  logic [1:0]   mode_sw,
  input  logic         btn_next,
  input  logic         btn_clear,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [2:0]   op,
  output logic         op_sum,
  output logic         op_subt,
  output logic         operands_valid,
  output logic         load_done,
  output logic [1:0]   state_o
);

  logic         w_next_pulse;
  logic         w_clear_pulse;
  state_t       r_state;
  state_t       w_state_next;
  logic         w_capture_a;
  logic         w_capture_b;
  logic         w_capture_op;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [2:0]   r_op;
  logic         r_op_sum;
  logic         r_op_subt;
  logic         r_load_done;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_next),
    .press_pulse (w_next_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_clear),
    .press_pulse (w_clear_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clear overrides next; a next pulse arriving together with clear is dropped.
  always_comb begin
    w_state_next = r_state;
    w_capture_a  = 1'b0;
    w_capture_b  = 1'b0;
    w_capture_op = 1'b0;
    if (w_clear_pulse) begin
      w_state_next = S_LOAD_A;
    end else if (w_next_pulse) begin
      unique case (r_state)
        S_LOAD_A: begin
          w_state_next = S_LOAD_B;
          w_capture_a  = 1'b1;
        end
        S_LOAD_B: begin
          w_state_next = S_LOAD_OP;
          w_capture_b  = 1'b1;
        end
        S_LOAD_OP: begin
          w_state_next = S_READY;
          w_capture_op = 1'b1;
        end
        S_READY: begin
          w_state_next = S_LOAD_A;
        end
      endcase
    end
  end

  // Leaving S_READY keeps the operands so the ALU result stays on display until the next loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_op_sum    <= 1'b0;
      r_op_subt   <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= w_capture_op;
      if (w_clear_pulse) begin
        r_a       <= '0;
        r_b       <= '0;
        r_op      <= '0;
        r_op_sum  <= 1'b0;
        r_op_subt <= 1'b0;
      end else begin
        if (w_capture_a) begin
          r_a <= sw;
        end
        if (w_capture_b) begin
          r_b <= sw;
        end
        if (w_capture_op) begin
          r_op      <= op_sw;
          r_op_sum  <= mode_sw[0];
          r_op_subt <= mode_sw[1];
        end
      end
    end
  end

  assign a              = r_a;
  assign b              = r_b;
  assign op             = r_op;
  assign op_sum         = r_op_sum;
  assign op_subt        = r_op_subt;
  assign load_done      = r_load_done;
  assign operands_valid = (r_state == S_READY);
  assign state_o        = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomised and directed bench for alu_operand_sequencer against a behavioural model of the load sequence.
module tb_alu_operand_sequencer;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sw;
  logic [2:0]   op_sw;
  logic [1:0]   mode_sw;
  logic         btn_next;
  logic         btn_clear;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   op;
  logic         op_sum;
  logic         op_subt;
  logic         operands_valid;
  logic         load_done;
  logic [1:0]   state_o;

  int checkCount = 0;
  int passCount  = 0;
  int ldPulses   = 0;

  alu_operand_sequencer #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw             (sw),
    .op_sw          (op_sw),
    .mode_sw        (mode_sw),
    .btn_next       (btn_next),
    .btn_clear      (btn_clear),
    .a              (a),
    .b              (b),
    .op             (op),
    .op_sum         (op_sum),
    .op_subt        (op_subt),
    .operands_valid (operands_valid),
    .load_done      (load_done),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Model: a button level is accepted once the D synchronised samples before it all disagree with the
  // accepted level; a press is the cycle after acceptance of a 1. Samples reach the filter two cycles late.
  int         mStep;
  logic [N-1:0] mA, mB;
  logic [2:0] mOp;
  logic [1:0] mMode;
  logic       mLoadDone;
  logic       mStable [2];
  logic       mStablePrev [2];
  logic       mPulse [2];
  logic       hist [2][D+2];
  logic       pN, pC, rawBit, newPulse, allDiff;

  always @(posedge clk) begin
    if (!rst_n) begin
      mStep = 0; mA = '0; mB = '0; mOp = '0; mMode = '0; mLoadDone = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mStable[i] = 1'b0; mStablePrev[i] = 1'b0; mPulse[i] = 1'b0;
        for (int j = 0; j < D + 2; j++) hist[i][j] = 1'b0;
      end
    end else begin
      pN = mPulse[0];
      pC = mPulse[1];
      mLoadDone = 1'b0;
      if (pC) begin
        mStep = 0; mA = '0; mB = '0; mOp = '0; mMode = '0;
      end else if (pN) begin
        case (mStep)
          0: mA = sw;
          1: mB = sw;
          2: begin mOp = op_sw; mMode = mode_sw; mLoadDone = 1'b1; end
          default: ;
        endcase
        mStep = (mStep + 1) % 4;
      end
      for (int i = 0; i < 2; i++) begin
        rawBit = (i == 0) ? btn_next : btn_clear;
        newPulse = mStable[i] & ~mStablePrev[i];
        mStablePrev[i] = mStable[i];
        for (int j = 0; j < D + 1; j++) hist[i][j] = hist[i][j+1];
        hist[i][D+1] = rawBit;
        allDiff = 1'b1;
        for (int j = 0; j < D; j++) if (hist[i][j] == mStable[i]) allDiff = 1'b0;
        if (allDiff) mStable[i] = ~mStable[i];
        mPulse[i] = newPulse;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    checkOutput("cycleOutputs",
                {state_o, a, b, op, op_subt, op_sum, operands_valid, load_done},
                {mStep[1:0], mA, mB, mOp, mMode, (mStep == 3), mLoadDone});
  end

  always @(negedge clk) if (load_done === 1'b1) ldPulses++;

  task automatic applyStimulus(input logic nxt, input logic clr, input int hold);
    @(negedge clk);
    btn_next  = nxt;
    btn_clear = clr;
    repeat (hold) @(negedge clk);
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic fullLoad();
    sw = 4'b0101;
    applyStimulus(1'b1, 1'b0, D + 4);
    sw = 4'b0011;
    applyStimulus(1'b1, 1'b0, D + 4);
    op_sw = 3'b110; mode_sw = 2'b01;
    applyStimulus(1'b1, 1'b0, D + 4);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int         ldBefore;
  int         latency;
  logic [N-1:0] sum4;
  int         r;
  int         hold;

  initial begin
    rst_n = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
    sw = '0; op_sw = '0; mode_sw = '0;

    // Reset held while buttons toggle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btn_next  = ~btn_next;
      btn_clear = i[0];
    end
    checkOutput("resetState", {state_o, a, b, op, op_sum, op_subt, operands_valid, load_done}, 32'd0);
    @(negedge clk);
    btn_next = 1'b0; btn_clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("idleAfterReset", {state_o, a, b, op, op_sum, op_subt, operands_valid, load_done}, 32'd0);

    // Full load sequence.
    ldBefore = ldPulses;
    fullLoad();
    checkOutput("loadA", a, 4'b0101);
    checkOutput("loadB", b, 4'b0011);
    checkOutput("loadOp", op, 3'b110);
    checkOutput("loadOpSum", op_sum, 1'b1);
    checkOutput("loadOpSubt", op_subt, 1'b0);
    checkOutput("loadState", state_o, 2'b11);
    checkOutput("loadValid", operands_valid, 1'b1);
    checkOutput("loadDoneCount", ldPulses - ldBefore, 1);
    sum4 = a + b;
    checkOutput("aluSum", sum4, 4'b1000);

    // Bounce: 2-cycle runs never accepted; final edge reaches the FSM one cycle after the D+3 pulse.
    applyStimulus(1'b0, 1'b1, D + 4);
    sw = 4'b1001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); btn_next = ~btn_next;
      @(negedge clk);
    end
    btn_next = 1'b1;
    latency = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #2;
      if (state_o !== 2'b00 && latency == 0) latency = i;
    end
    checkOutput("bounceLatency", latency, D + 4);
    @(negedge clk); btn_next = 1'b0;
    repeat (D + 6) @(negedge clk);
    checkOutput("bounceState", state_o, 2'b01);
    checkOutput("bounceA", a, 4'b1001);

    // Clear mid-sequence from S_LOAD_OP.
    applyStimulus(1'b1, 1'b0, D + 4);
    checkOutput("inLoadOp", state_o, 2'b10);
    ldBefore = ldPulses;
    applyStimulus(1'b0, 1'b1, D + 4);
    checkOutput("clearState", {state_o, a, b, op, operands_valid}, 32'd0);
    checkOutput("clearNoLoadDone", ldPulses - ldBefore, 0);

    // Simultaneous next and clear from S_LOAD_B.
    sw = 4'b0111;
    applyStimulus(1'b1, 1'b0, D + 4);
    checkOutput("simulPreA", a, 4'b0111);
    sw = 4'b1110;
    applyStimulus(1'b1, 1'b1, D + 4);
    checkOutput("simulState", state_o, 2'b00);
    checkOutput("simulB", b, 4'b0000);
    checkOutput("simulA", a, 4'b0000);

    // Wrap from S_READY and long hold.
    fullLoad();
    sw = 4'b1111; op_sw = 3'b001;
    applyStimulus(1'b1, 1'b0, 50);
    checkOutput("wrapState", state_o, 2'b00);
    checkOutput("wrapKeep", {a, b, op}, {4'b0101, 4'b0011, 3'b110});

    // Randomised phase; the per-cycle compare tracks the model throughout.
    for (int it = 0; it < 200; it++) begin
      @(negedge clk);
      sw = N'($urandom); op_sw = 3'($urandom); mode_sw = 2'($urandom);
      r = $urandom_range(0, 19);
      hold = $urandom_range(1, D + 6);
      if (r == 0) begin
        rst_n = 1'b0;
        btn_next = 1'($urandom); btn_clear = 1'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        btn_next = 1'b0; btn_clear = 1'b0;
        rst_n = 1'b1;
      end else if (r < 17) begin
        btn_next  = (r < 10) || (r >= 14);
        btn_clear = (r >= 10);
        for (int k = 0; k < hold; k++) begin
          @(negedge clk);
          sw = N'($urandom); op_sw = 3'($urandom); mode_sw = 2'($urandom);
        end
      end else begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          btn_next = 1'($urandom); btn_clear = ($urandom_range(0, 7) == 0);
        end
      end
      btn_next = 1'b0; btn_clear = 1'b0;
      repeat ($urandom_range(1, D + 6)) @(negedge clk);
    end

    repeat (D + 8) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
